// File: rtl/q2a03_bus_target.sv
// q2a03_bus_target: Q2A03 CPU bus responder with mirrored 2 KiB work RAM,
// a wait-stated slow RAM window at $6000-$7FFF and open-bus emulation.
// Define Q2A03_BUS_TIMER_EN to add a reload timer at $4018-$401A driving G_irq.
module q2a03_bus_target #(
    parameter int unsigned RAM_AW      = 11,
    parameter int unsigned SLOW_AW     = 13,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    input  logic        G_sync,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        G_irq
);

    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WAIT_STATES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StGrant = 2'd2;

    localparam logic [1:0] RegNone  = 2'd0;
    localparam logic [1:0] RegWram  = 2'd1;
    localparam logic [1:0] RegSlow  = 2'd2;
    localparam logic [1:0] RegTimer = 2'd3;

    // G_sync is informational only on this bus side.
    logic unused_sync;
    assign unused_sync = G_sync;

    logic               phy2_q;
    logic               rise;
    logic               fall;
    logic [SLOW_AW-1:0] addr_q;
    logic               rdwr_q;
    logic [7:0]         wdata_q;
    logic [1:0]         region_q;
    logic [1:0]         region_d;
    logic               valid_q;
    logic               blocked_q;
    logic               blocked_d;
    logic               rise_d1_q;
    logic               rise_d2_q;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CntW-1:0]    cnt_q;
    logic [CntW-1:0]    cnt_d;
    logic               ready_q;
    logic               ready_d;

    logic [7:0]         rd_data_q;
    logic [7:0]         open_bus_q;
    logic [7:0]         arr_rd_q;
    logic [7:0]         read_val;
    logic [7:0]         timer_rd;

    logic               commit;
    logic               wram_we;
    logic               slow_we;

    logic [7:0]         wram     [0:(1 << RAM_AW) - 1];
    logic [7:0]         slow_mem [0:(1 << SLOW_AW) - 1];

    assign rise = G_phy2 & ~phy2_q;
    assign fall = phy2_q & ~G_phy2;

    // Region decode of the live address, used at the rise clock.
    always_comb begin
        region_d = RegNone;
        if (G_addr[15:13] == 3'd0) begin
            region_d = RegWram;
        end else if (G_addr[15:13] == 3'd3) begin
            region_d = RegSlow;
`ifdef Q2A03_BUS_TIMER_EN
        end else if (G_addr >= 16'h4018 && G_addr <= 16'h401A) begin
            region_d = RegTimer;
`endif
        end
    end

    // An access is not served if it starts the wait sequence or arrives while waiting.
    assign blocked_d = (state_q == StWait) ||
                       ((state_q == StIdle) && (region_d == RegSlow) && (WAIT_STATES != 0));

    assign commit  = fall & valid_q & ~rdwr_q & ~blocked_q;
    assign wram_we = commit & (region_q == RegWram);
    assign slow_we = commit & (region_q == RegSlow);

    // Edge tracking and bus-cycle capture; valid_q gates commits so a stray fall is ignored.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            phy2_q    <= 1'b0;
            addr_q    <= '0;
            rdwr_q    <= 1'b1;
            wdata_q   <= 8'h00;
            region_q  <= RegNone;
            valid_q   <= 1'b0;
            blocked_q <= 1'b0;
            rise_d1_q <= 1'b0;
            rise_d2_q <= 1'b0;
        end else begin
            phy2_q    <= G_phy2;
            rise_d1_q <= rise;
            rise_d2_q <= rise_d1_q;
            if (rise) begin
                addr_q    <= G_addr[SLOW_AW-1:0];
                rdwr_q    <= G_rdwr;
                wdata_q   <= G_wr_data;
                region_q  <= region_d;
                valid_q   <= 1'b1;
                blocked_q <= blocked_d;
            end else if (fall) begin
                valid_q   <= 1'b0;
            end
        end
    end

    // Wait-state sequencing: G_ready only moves on rise or fall clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        unique case (state_q)
            StIdle: begin
                if (rise && (region_d == RegSlow) && (WAIT_STATES != 0)) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                    ready_d = 1'b0;
                end
            end
            StWait: begin
                if (fall) begin
                    if (cnt_q <= CntOne) begin
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = StGrant;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StGrant: begin
                if (rise && (region_d != RegSlow)) begin
                    state_d = StIdle;
                end else if (fall && valid_q && !blocked_q && (region_q == RegSlow)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    // Wait-state registers.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // RAM arrays (never reset) and the array read one clock after rise.
    always_ff @(posedge G_clock) begin
        if (wram_we) begin
            wram[addr_q[RAM_AW-1:0]] <= wdata_q;
        end
        if (slow_we) begin
            slow_mem[addr_q] <= wdata_q;
        end
        if (rise_d1_q) begin
            case (region_q)
                RegWram:  arr_rd_q <= wram[addr_q[RAM_AW-1:0]];
                RegSlow:  arr_rd_q <= slow_mem[addr_q];
                RegTimer: arr_rd_q <= timer_rd;
                default:  arr_rd_q <= 8'h00;
            endcase
        end
    end

    // Unserved or unmapped reads reflect the open-bus latch.
    assign read_val = (!blocked_q && (region_q != RegNone)) ? arr_rd_q : open_bus_q;

    // Read data register and open-bus latch.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            rd_data_q  <= 8'h00;
            open_bus_q <= 8'h00;
        end else begin
            if (fall && valid_q && !rdwr_q) begin
                open_bus_q <= wdata_q;
            end
            if (rise_d2_q && valid_q && rdwr_q) begin
                rd_data_q  <= read_val;
                open_bus_q <= read_val;
            end
        end
    end

    assign G_rd_data = rd_data_q;
    assign G_ready   = ready_q;

`ifdef Q2A03_BUS_TIMER_EN
    logic [15:0] reload_q;
    logic [15:0] tcnt_q;
    logic        run_q;
    logic        irq_en_q;
    logic        flag_q;
    logic        tmr_we;
    logic        tmr_expire;

    assign tmr_we     = commit & (region_q == RegTimer);
    assign tmr_expire = fall & run_q & (tcnt_q == 16'h0000);

    // Timer register read mux.
    always_comb begin
        timer_rd = 8'h00;
        case (addr_q[1:0])
            2'd0:    timer_rd = reload_q[7:0];
            2'd1:    timer_rd = reload_q[15:8];
            2'd2:    timer_rd = {flag_q, 5'b00000, irq_en_q, run_q};
            default: timer_rd = 8'h00;
        endcase
    end

    // Timer: counts falls while running; register writes reload it; expiry beats flag clear.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            reload_q <= 16'h0000;
            tcnt_q   <= 16'h0000;
            run_q    <= 1'b0;
            irq_en_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            if (fall && run_q) begin
                if (tcnt_q == 16'h0000) begin
                    tcnt_q <= reload_q;
                end else begin
                    tcnt_q <= tcnt_q - 16'd1;
                end
            end
            if (tmr_we) begin
                case (addr_q[1:0])
                    2'd0: begin
                        reload_q[7:0] <= wdata_q;
                        tcnt_q        <= {reload_q[15:8], wdata_q};
                    end
                    2'd1: begin
                        reload_q[15:8] <= wdata_q;
                        tcnt_q         <= {wdata_q, reload_q[7:0]};
                    end
                    default: begin
                        run_q    <= wdata_q[0];
                        irq_en_q <= wdata_q[1];
                        tcnt_q   <= reload_q;
                        if (wdata_q[7]) begin
                            flag_q <= 1'b0;
                        end
                    end
                endcase
            end
            if (tmr_expire) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign G_irq = ~(flag_q & irq_en_q);
`else
    assign timer_rd = 8'h00;
    assign G_irq    = 1'b1;
`endif

endmodule
